// File: rtl/bus_drive_mux_if.sv
// Bus-drive multiplexer signal bundle: source enables/data in, registered bus and
// conflict-tracking outputs back to the control unit.
interface bus_drive_mux_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 24,
   parameter int CNTW  = 8
);
   localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [NSRC*WIDTH-1:0] src_data;
   logic [NSRC-1:0]       src_out;
   logic                  hold;
   logic                  conflict_clr;
   logic [WIDTH-1:0]      bus_out;
   logic [SELW-1:0]       bus_sel;
   logic                  bus_valid;
   logic                  conflict;
   logic                  conflict_sticky;
   logic [CNTW-1:0]       conflict_cnt;

   modport master (
      output src_data, src_out, hold, conflict_clr,
      input  bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_cnt
   );

   modport slave (
      input  src_data, src_out, hold, conflict_clr,
      output bus_out, bus_sel, bus_valid, conflict, conflict_sticky, conflict_cnt
   );
endinterface

// File: rtl/bus_drive_mux.sv
// Registered datapath bus multiplexer: encodes one-hot drive enables, holds the
// last driven value when idle, and flags/counts multi-driver conflicts.
module bus_drive_mux #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 24,
   parameter int CNTW  = 8
) (
   input logic             clock,
   input logic             clear_n,
   bus_drive_mux_if.slave  bif
);
   localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [WIDTH-1:0] bus_out_q, bus_out_d;
   logic [SELW-1:0]  bus_sel_q, bus_sel_d;
   logic             bus_valid_q, bus_valid_d;
   logic             conflict_q, conflict_d;
   logic             sticky_q, sticky_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic             hit;
   logic             multi;
   logic [SELW-1:0]  idx;
   logic [WIDTH-1:0] sel_data;
   logic [NSRC-1:0]  src_less_one;

   // Descending scan so the lowest set index is the last (winning) assignment.
   always_comb begin
      hit      = 1'b0;
      idx      = '0;
      sel_data = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (bif.src_out[i]) begin
            hit      = 1'b1;
            idx      = SELW'(i);
            sel_data = bif.src_data[i*WIDTH +: WIDTH];
         end
      end
      src_less_one = bif.src_out - NSRC'(1);
      multi        = |(bif.src_out & src_less_one);
   end

   always_comb begin
      bus_out_d   = bus_out_q;
      bus_sel_d   = bus_sel_q;
      bus_valid_d = bus_valid_q;
      if (!bif.hold) begin
         bus_valid_d = hit;
         if (hit) begin
            bus_out_d = sel_data;
            bus_sel_d = idx;
         end
      end

      conflict_d = multi;
      // A conflict arriving together with a clear is kept as the first new event.
      if (bif.conflict_clr) begin
         sticky_d = multi;
         cnt_d    = multi ? CNTW'(1) : '0;
      end else begin
         sticky_d = sticky_q | multi;
         cnt_d    = (multi && (cnt_q != '1)) ? cnt_q + CNTW'(1) : cnt_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         bus_out_q   <= '0;
         bus_sel_q   <= '0;
         bus_valid_q <= 1'b0;
         conflict_q  <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         bus_out_q   <= bus_out_d;
         bus_sel_q   <= bus_sel_d;
         bus_valid_q <= bus_valid_d;
         conflict_q  <= conflict_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bif.bus_out         = bus_out_q;
   assign bif.bus_sel         = bus_sel_q;
   assign bif.bus_valid       = bus_valid_q;
   assign bif.conflict        = conflict_q;
   assign bif.conflict_sticky = sticky_q;
   assign bif.conflict_cnt    = cnt_q;
endmodule

// File: tb/tb_bus_drive_mux.sv
// Bench for bus_drive_mux: directed scenarios plus randomized traffic on a 32x24
// instance and a 16x5 instance, each checked against a cycle-level reference model.
module tb_bus_drive_mux;
   localparam int CMAX = 255;

   typedef struct {
      logic [31:0] out;
      int          sel;
      bit          valid;
      bit          conf;
      bit          sticky;
      int          cnt;
   } st_t;

   logic clock;
   logic clear_n;
   int   vectors;
   int   miscompares;
   st_t  sa, sb;

   bus_drive_mux_if #(.WIDTH(32), .NSRC(24), .CNTW(8)) a_if ();
   bus_drive_mux_if #(.WIDTH(16), .NSRC(5),  .CNTW(8)) b_if ();

   bus_drive_mux #(.WIDTH(32), .NSRC(24), .CNTW(8)) u_a (
      .clock(clock), .clear_n(clear_n), .bif(a_if.slave));
   bus_drive_mux #(.WIDTH(16), .NSRC(5), .CNTW(8)) u_b (
      .clock(clock), .clear_n(clear_n), .bif(b_if.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Next-cycle outputs derived directly from the behavioural rules.
   function automatic st_t model(st_t s, bit rst_n, int nsrc, int width,
                                 logic [63:0] so, logic [767:0] sd, bit hold, bit clr);
      st_t n;
      int  k;
      int  first;
      logic [31:0] mask;
      n = s;
      if (!rst_n) begin
         n = '{out: 32'd0, sel: 0, valid: 1'b0, conf: 1'b0, sticky: 1'b0, cnt: 0};
         return n;
      end
      k = $countones(so);
      first = -1;
      for (int i = 0; i < nsrc; i++)
         if (so[i] && first < 0) first = i;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      if (!hold) begin
         n.valid = (k > 0);
         if (k > 0) begin
            n.out = 32'(sd >> (first * width)) & mask;
            n.sel = first;
         end
      end
      n.conf = (k > 1);
      if (clr) begin
         n.cnt    = (k > 1) ? 1 : 0;
         n.sticky = (k > 1);
      end else if (k > 1) begin
         n.sticky = 1'b1;
         n.cnt    = (s.cnt < CMAX) ? s.cnt + 1 : CMAX;
      end
      return n;
   endfunction

   task automatic step();
      @(posedge clock);
      sa = model(sa, clear_n, 24, 32, 64'(a_if.src_out), a_if.src_data,
                 a_if.hold, a_if.conflict_clr);
      sb = model(sb, clear_n, 5, 16, 64'(b_if.src_out), 768'(b_if.src_data),
                 b_if.hold, b_if.conflict_clr);
      #1;
      chk("a_out",    64'(a_if.bus_out),         64'(sa.out));
      chk("a_sel",    64'(a_if.bus_sel),         64'(sa.sel));
      chk("a_valid",  64'(a_if.bus_valid),       64'(sa.valid));
      chk("a_conf",   64'(a_if.conflict),        64'(sa.conf));
      chk("a_sticky", 64'(a_if.conflict_sticky), 64'(sa.sticky));
      chk("a_cnt",    64'(a_if.conflict_cnt),    64'(sa.cnt));
      chk("b_out",    64'(b_if.bus_out),         64'(sb.out[15:0]));
      chk("b_sel",    64'(b_if.bus_sel),         64'(sb.sel));
      chk("b_valid",  64'(b_if.bus_valid),       64'(sb.valid));
      chk("b_conf",   64'(b_if.conflict),        64'(sb.conf));
      chk("b_sticky", 64'(b_if.conflict_sticky), 64'(sb.sticky));
      chk("b_cnt",    64'(b_if.conflict_cnt),    64'(sb.cnt));
   endtask

   function automatic logic [63:0] rand_enables(int nsrc);
      logic [63:0] v;
      int mode;
      mode = $urandom_range(0, 3);
      v = '0;
      case (mode)
         0: v = '0;
         1: v[$urandom_range(0, nsrc - 1)] = 1'b1;
         2: begin
            v[$urandom_range(0, nsrc - 1)] = 1'b1;
            v[$urandom_range(0, nsrc - 1)] = 1'b1;
         end
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      sa = '{out: 32'd0, sel: 0, valid: 1'b0, conf: 1'b0, sticky: 1'b0, cnt: 0};
      sb = sa;
      for (int i = 0; i < 24; i++) a_if.src_data[i*32 +: 32] = $urandom;
      for (int i = 0; i < 5; i++)  b_if.src_data[i*16 +: 16] = 16'($urandom);
      a_if.hold = 1'b0; a_if.conflict_clr = 1'b0;
      b_if.hold = 1'b0; b_if.conflict_clr = 1'b0;

      // Reset with every source driving
      clear_n = 1'b0;
      a_if.src_out = '1;
      b_if.src_out = '1;
      step();
      step();
      chk("rst_out", 64'(a_if.bus_out), 64'd0);
      chk("rst_cnt", 64'(a_if.conflict_cnt), 64'd0);

      // Single driver
      clear_n = 1'b1;
      a_if.src_data[5*32 +: 32] = 32'hDEAD_BEEF;
      a_if.src_out = 24'd1 << 5;
      b_if.src_out = '0;
      step();
      chk("t2_out",   64'(a_if.bus_out), 64'hDEAD_BEEF);
      chk("t2_sel",   64'(a_if.bus_sel), 64'd5);
      chk("t2_valid", 64'(a_if.bus_valid), 64'd1);
      chk("t2_conf",  64'(a_if.conflict), 64'd0);

      // Bus hold when idle, then explicit hold
      a_if.src_out = '0;
      step();
      chk("t3_out",   64'(a_if.bus_out), 64'hDEAD_BEEF);
      chk("t3_sel",   64'(a_if.bus_sel), 64'd5);
      chk("t3_valid", 64'(a_if.bus_valid), 64'd0);
      a_if.hold = 1'b1;
      a_if.src_out = 24'd1 << 7;
      step();
      chk("t3h_out", 64'(a_if.bus_out), 64'hDEAD_BEEF);
      chk("t3h_sel", 64'(a_if.bus_sel), 64'd5);
      a_if.hold = 1'b0;

      // Conflict and saturation
      a_if.src_out = (24'd1 << 3) | (24'd1 << 20);
      step();
      chk("t4_sel",  64'(a_if.bus_sel), 64'd3);
      chk("t4_out",  64'(a_if.bus_out), 64'(a_if.src_data[3*32 +: 32]));
      chk("t4_cnt1", 64'(a_if.conflict_cnt), 64'd1);
      for (int i = 0; i < 299; i++) step();
      chk("t4_sat",  64'(a_if.conflict_cnt), 64'd255);

      // Clear racing a conflict, then a clean clear
      a_if.conflict_clr = 1'b1;
      step();
      chk("t5_cnt",    64'(a_if.conflict_cnt), 64'd1);
      chk("t5_sticky", 64'(a_if.conflict_sticky), 64'd1);
      a_if.src_out = 24'd1;
      step();
      chk("t5c_cnt",    64'(a_if.conflict_cnt), 64'd0);
      chk("t5c_sticky", 64'(a_if.conflict_sticky), 64'd0);
      a_if.conflict_clr = 1'b0;

      // Reset mid-stream with conflict and hold asserted
      a_if.src_out = '1;
      a_if.hold = 1'b1;
      clear_n = 1'b0;
      step();
      chk("mrst_valid", 64'(a_if.bus_valid), 64'd0);
      chk("mrst_out",   64'(a_if.bus_out), 64'd0);
      clear_n = 1'b1;
      a_if.hold = 1'b0;

      // Randomized traffic on both instances
      for (int n = 0; n < 600; n++) begin
         a_if.src_out = 24'(rand_enables(24));
         b_if.src_out = 5'(rand_enables(5));
         a_if.src_data[$urandom_range(0, 23)*32 +: 32] = $urandom;
         b_if.src_data[$urandom_range(0, 4)*16 +: 16] = 16'($urandom);
         a_if.hold = ($urandom_range(0, 3) == 0);
         b_if.hold = ($urandom_range(0, 3) == 0);
         a_if.conflict_clr = ($urandom_range(0, 19) == 0);
         b_if.conflict_clr = ($urandom_range(0, 19) == 0);
         clear_n = ($urandom_range(0, 49) != 0);
         step();
      end

      // Walk a single driver across the narrow instance
      clear_n = 1'b1;
      b_if.hold = 1'b0;
      b_if.conflict_clr = 1'b0;
      for (int i = 0; i < 5; i++) b_if.src_data[i*16 +: 16] = 16'(i * 16'h1111);
      for (int i = 0; i < 5; i++) begin
         b_if.src_out = 5'd1 << i;
         step();
         chk("t6_sel", 64'(b_if.bus_sel), 64'(i));
         chk("t6_out", 64'(b_if.bus_out), 64'(i * 16'h1111));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
